seq_divider_16bit: RTL and testbench
====================================

Name: seq_divider_16bit

Overview:
Multi-cycle restoring integer divider, the inverse companion to the Vedic multiplier datapath. It is used to check products (p / a == b) and to undo scaling. It computes one quotient bit per clock with a start/busy/done handshake. Results are registered and held until the next accepted start.

Parameters:
WIDTH, 16, operand/result width in bits; legal values are 8, 16 and 32.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled on rising clk edge
dividend  input  WIDTH  numerator; sampled only when start is accepted
divisor  input  WIDTH  denominator; sampled only when start is accepted
busy  output  1  high while division in progress
done  output  1  single-cycle pulse; results valid from this cycle
quotient  output  WIDTH  registered quotient
remainder  output  WIDTH  registered remainder
div_by_zero  output  1  registered flag for the last completed operation

Behaviour:
- Reset (rst_n low, asynchronous, any state):
  - state=IDLE;
  - busy=0, done=0, quotient=0, remainder=0, div_by_zero=0;
  - internal accumulator and counter cleared.
- Reset mid-operation aborts the operation. No done is produced for it.
- FSM states: IDLE, RUN, DONE.
- Start acceptance:
  - start is accepted only in IDLE or DONE.
  - start high while busy=1 is ignored and does not corrupt the operation in progress.
- Let edge E0 be the edge at which start is accepted:
  - dividend and divisor are latched at E0.
  - busy=1 from E0.
  - The iteration counter is loaded with WIDTH.
  - Normal path: state goes to RUN.
  - Divisor==0 path: go straight to DONE at E0. Do not iterate.
- RUN, at each edge E1..E(WIDTH), one restoring step:
  - {rem,q} shift left 1;
  - trial = rem - divisor, computed WIDTH+1 bits wide so there is no overflow;
  - if trial is non-negative: rem=trial, q[0]=1; otherwise q[0]=0;
  - counter decrements.
- Completion at E(WIDTH), i.e. when the counter reaches 0 on that edge:
  - quotient and remainder are written;
  - done=1 for exactly one cycle; busy=0; state=DONE.
- Latency: done is high WIDTH cycles after E0 (16 cycles at default).
- Divide-by-zero: done is high 1 cycle after E0, with quotient=all ones, remainder=dividend, div_by_zero=1.
- div_by_zero is cleared at the completion of any non-zero-divisor operation.
- DONE:
  - outputs are held;
  - if start is high, the new operation is accepted on the same edge (back-to-back, no IDLE bubble);
  - otherwise the state moves to IDLE with outputs still held.
- Invariant, unsigned mode: dividend == quotient*divisor + remainder, and remainder < divisor.
- done and busy are never high in the same cycle.

Optional Feature:
SEQ_DIV_SIGNED_EN:
- Defined:
  - operands are two's complement;
  - magnitudes are divided with the same RUN sequence;
  - the quotient is negated when the operand signs differ;
  - the remainder takes the dividend's sign (truncation toward zero);
  - sign fix-up is applied combinationally at the completion write, so latency is unchanged;
  - overflow case most-negative / -1: quotient=most-negative (0x8000 at WIDTH=16), remainder=0, div_by_zero=0;
  - divide-by-zero behaves as above: quotient=all ones (-1), remainder=dividend.
- Undefined: purely unsigned operation, and no sign logic is synthesized.

Test Plan:
- Basic divide: dividend=100, divisor=7, start for 1 cycle → done pulses exactly 16 cycles after start edge; quotient=14, remainder=2, div_by_zero=0; busy high 16 cycles.
- Extremes: 0xFFFF/0x0001 → q=0xFFFF, r=0. Then 0x0005/0x0009 → q=0, r=5. Then 0x0000/0x1234 → q=0, r=0.
- Divide-by-zero: 0x1234/0 → done 1 cycle after start; q=0xFFFF, r=0x1234, div_by_zero=1. Then 50/5 → q=10, r=0, div_by_zero=0.
- Handshake: start held high continuously with changing operands → only the value at acceptance is used. Back-to-back 200/3 then 81/9 give q=66,r=2 then q=9,r=0, each done spaced exactly 16 cycles.
- Reset: assert rst_n low at cycle 8 of an operation → all outputs 0 immediately (asynchronous). After release no done appears until a new start; next op 9/4 → q=2, r=1.
- Signed (SEQ_DIV_SIGNED_EN): -7/2 → q=0xFFFD, r=0xFFFF. Then 7/-2 → q=0xFFFD, r=1. Then 0x8000/0xFFFF → q=0x8000, r=0.

Source files
------------

// File: rtl/seq_divider_16bit.sv
// rtl/seq_divider_16bit.sv - restoring divider, one quotient bit per clock, start/busy/done handshake.
// Define SEQ_DIV_SIGNED_EN for two's complement operands (truncating division); default build is unsigned.
module seq_divider_16bit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;
  logic             zpend_q, zpend_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] qacc_q, qacc_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic [WIDTH-1:0] dvnd_q, dvnd_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             accept;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;
  logic [WIDTH-1:0] q_step, r_step;
  logic [WIDTH-1:0] q_fix, r_fix;

`ifdef SEQ_DIV_SIGNED_EN
  logic qneg_q, qneg_d;
  logic rneg_q, rneg_d;

  // The most-negative operand maps onto itself, which is its correct unsigned magnitude.
  assign mag_a = dividend[WIDTH-1] ? (~dividend + 1'b1) : dividend;
  assign mag_b = divisor[WIDTH-1]  ? (~divisor + 1'b1)  : divisor;
  assign q_fix = qneg_q ? (~q_step + 1'b1) : q_step;
  assign r_fix = rneg_q ? (~r_step + 1'b1) : r_step;

  always_comb begin
    qneg_d = qneg_q;
    rneg_d = rneg_q;
    if (accept) begin
      qneg_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
      rneg_d = dividend[WIDTH-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
    end else begin
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
    end
  end
`else
  assign mag_a = dividend;
  assign mag_b = divisor;
  assign q_fix = q_step;
  assign r_fix = r_step;
`endif

  assign accept = start && ((state_q == IDLE) || ((state_q == DONE) && !zpend_q));

  // Restoring step: the extra top bit of trial is the borrow, i.e. the sign of rem - divisor.
  assign shifted = {acc_q, qacc_q[WIDTH-1]};
  assign trial   = {1'b0, shifted} - {2'b00, dvsr_q};
  assign q_step  = {qacc_q[WIDTH-2:0], ~trial[WIDTH+1]};
  assign r_step  = trial[WIDTH+1] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];

  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dbz_d   = dbz_q;
    zpend_d = zpend_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    acc_d   = acc_q;
    qacc_d  = qacc_q;
    dvsr_d  = dvsr_q;
    dvnd_d  = dvnd_q;
    cnt_d   = cnt_q;

    if (accept) begin
      busy_d = 1'b1;
      acc_d  = '0;
      qacc_d = mag_a;
      dvsr_d = mag_b;
      dvnd_d = dividend;
      cnt_d  = CW'(WIDTH);
      if (divisor == '0) begin
        state_d = DONE;
        zpend_d = 1'b1;
      end else begin
        state_d = RUN;
      end
    end else begin
      case (state_q)
        RUN: begin
          acc_d  = r_step;
          qacc_d = q_step;
          cnt_d  = cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            quot_d  = q_fix;
            rem_d   = r_fix;
            dbz_d   = 1'b0;
          end
        end
        DONE: begin
          // A zero divisor parks here for one cycle so done still trails the start edge.
          if (zpend_q) begin
            zpend_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            quot_d  = '1;
            rem_d   = dvnd_q;
            dbz_d   = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      zpend_q <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      acc_q   <= '0;
      qacc_q  <= '0;
      dvsr_q  <= '0;
      dvnd_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
      zpend_q <= zpend_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      acc_q   <= acc_d;
      qacc_q  <= qacc_d;
      dvsr_q  <= dvsr_d;
      dvnd_q  <= dvnd_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider_16bit.sv
// tb/tb_seq_divider_16bit.sv - scoreboard bench for seq_divider_16bit with a behavioural division model.
module tb_seq_divider_16bit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] dividend = '0;
  logic [15:0] divisor = '0;
  logic        busy, done, div_by_zero;
  logic [15:0] quotient, remainder;

  seq_divider_16bit #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    logic        dz;
    int          lat;
    int          e0;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   busy_run = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input int e0);
    exp_t e;
    int   sa, sb_i;
    e.e0 = e0;
    e.lat = 16;
    e.dz = 1'b0;
    if (b == 16'h0) begin
      e.q = 16'hFFFF;
      e.r = a;
      e.dz = 1'b1;
      e.lat = 1;
    end else begin
`ifdef SEQ_DIV_SIGNED_EN
      sa = int'($signed(a));
      sb_i = int'($signed(b));
      e.q = 16'(sa / sb_i);
      e.r = 16'(sa % sb_i);
`else
      sa = int'(a);
      sb_i = int'(b);
      e.q = 16'(sa / sb_i);
      e.r = 16'(sa % sb_i);
`endif
    end
    return e;
  endfunction

  // Monitor: every done pulse is matched against the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_run = 0;
    end else begin
      if (done) begin
        check("busy_with_done", {31'd0, busy}, 32'd0);
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL spurious_done: got done=1 required no pending operation (cycle %0d)", cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("quotient", {16'd0, quotient}, {16'd0, e.q});
          check("remainder", {16'd0, remainder}, {16'd0, e.r});
          check("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dz});
          check("done_latency", 32'(cyc - e.e0), 32'(e.lat));
          check("busy_cycles", 32'(busy_run), 32'(e.lat));
        end
      end
      if (busy) busy_run++;
      else busy_run = 0;
    end
  end

  task automatic issue(input logic [15:0] a, input logic [15:0] b);
    start = 1'b1;
    dividend = a;
    divisor = b;
    @(posedge clk);
    #1;
    sb.push_back(model(a, b, cyc));
    start = 1'b0;
    dividend = 16'($urandom);
    divisor = 16'($urandom);
  endtask

  task automatic wait_done(input bit noise);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        start = 1'b0;
      end else if (noise) begin
        start = 1'($urandom);
        dividend = 16'($urandom);
        divisor = 16'($urandom);
      end
    end
    if (!seen) begin
      tests++;
      fails++;
      $display("FAIL done_timeout: got no done required done within 40 cycles");
    end
  endtask

  initial begin
    #12;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_quotient", {16'd0, quotient}, 32'd0);
    check("rst_remainder", {16'd0, remainder}, 32'd0);
    check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed operations, each issued in the done cycle of the previous one.
    issue(16'd100, 16'd7);      wait_done(1'b0);
    issue(16'hFFFF, 16'h0001);  wait_done(1'b0);
    issue(16'h0005, 16'h0009);  wait_done(1'b0);
    issue(16'h0000, 16'h1234);  wait_done(1'b0);
    issue(16'h1234, 16'h0000);  wait_done(1'b0);
    issue(16'd50, 16'd5);       wait_done(1'b0);
    repeat (3) @(negedge clk);

    // start held high with operands changing while busy.
    start = 1'b1;
    dividend = 16'd200;
    divisor = 16'd3;
    @(posedge clk);
    #1;
    sb.push_back(model(16'd200, 16'd3, cyc));
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) break;
      dividend = 16'($urandom);
      divisor = 16'($urandom);
    end
    issue(16'd81, 16'd9);
    wait_done(1'b0);
    repeat (2) @(negedge clk);

    // Asynchronous reset in the middle of an operation.
    issue(16'hBEEF, 16'h0013);
    repeat (8) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_quotient", {16'd0, quotient}, 32'd0);
    check("midrst_remainder", {16'd0, remainder}, 32'd0);
    check("midrst_dbz", {31'd0, div_by_zero}, 32'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("post_rst_busy", {31'd0, busy}, 32'd0);
    issue(16'd9, 16'd4);
    wait_done(1'b0);

`ifdef SEQ_DIV_SIGNED_EN
    issue(16'hFFF9, 16'h0002);  wait_done(1'b0);
    issue(16'h0007, 16'hFFFE);  wait_done(1'b0);
    issue(16'h8000, 16'hFFFF);  wait_done(1'b0);
`endif

    // Randomized operations with start noise while busy and random idle gaps.
    for (int n = 0; n < 40; n++) begin
      logic [15:0] a, b;
      a = 16'($urandom);
      case ($urandom_range(0, 3))
        0: b = 16'($urandom_range(0, 3));
        1: b = 16'($urandom_range(1, 255));
        2: b = a;
        default: b = 16'($urandom);
      endcase
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
      issue(a, b);
      wait_done(1'b1);
    end

    repeat (5) @(negedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
